// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU: opcodes, sequencer states, ALU codes.
// Opcode lives in IR[7:4]; ALU codes are the opcode values the ALU decodes.
// The strobe bundle groups every control output the sequencer drives.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_STA = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_XOR = 4'h7,
        OP_NOT = 4'h8,
        OP_SHL = 4'h9,
        OP_SHR = 4'hA,
        OP_JMP = 4'hB,
        OP_JZ  = 4'hC,
        OP_JC  = 4'hD,
        OP_JS  = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ST_RESET_LD = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_OPFETCH  = 3'd3,
        ST_EXEC     = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

    // ALU operation codes; the ALU decodes these same values.
    localparam logic [3:0] ALU_NONE = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h3;
    localparam logic [3:0] ALU_SUB  = 4'h4;
    localparam logic [3:0] ALU_AND  = 4'h5;
    localparam logic [3:0] ALU_OR   = 4'h6;
    localparam logic [3:0] ALU_XOR  = 4'h7;
    localparam logic [3:0] ALU_NOT  = 4'h8;
    localparam logic [3:0] ALU_SHL  = 4'h9;
    localparam logic [3:0] ALU_SHR  = 4'hA;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       addr_sel;
        logic       pc_inc;
        logic       pc_load;
        logic [3:0] alu_op;
        logic       acc_load;
        logic       acc_src;
        logic       fr_load;
        logic       halted;
    } strobe_t;

    // Opcodes that carry an operand/immediate byte after the opcode byte.
    function automatic logic is_two_byte(input opcode_t op);
        return ((op >= OP_LDA) && (op <= OP_XOR)) ||
               ((op >= OP_JMP) && (op <= OP_JS));
    endfunction

    // Map an ALU-class opcode to the code presented on ALU_OP.
    function automatic logic [3:0] to_alu_op(input opcode_t op);
        logic [3:0] code;
        case (op)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            OP_XOR:  code = ALU_XOR;
            OP_NOT:  code = ALU_NOT;
            OP_SHL:  code = ALU_SHL;
            OP_SHR:  code = ALU_SHR;
            default: code = ALU_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Control strobe decoder: state, opcode, flags and MEM_READY to strobe vector.
// Purely combinational, zero latency.
// Requests are held constant while in a request state; MEM_READY only gates completion strobes.
module cpu_seq_decode
    import cpu_pkg::*;
(
    input  state_t  state_i,
    input  opcode_t opcode_i,
    input  logic    mem_ready_i,
    input  logic    cy_i,
    input  logic    z_i,
    input  logic    s_i,
    output strobe_t strb_o
);

    // Strobes for the current state; everything defaults low so HALT and DECODE stay quiet.
    always_comb begin
        strb_o = '0;
        case (state_i)
            ST_RESET_LD: strb_o.pc_load = 1'b1;
            ST_FETCH, ST_OPFETCH: begin
                strb_o.mem_rd = 1'b1;
                strb_o.pc_inc = mem_ready_i;
            end
            ST_EXEC: begin
                case (opcode_i)
                    OP_LDA: begin
                        strb_o.mem_rd   = 1'b1;
                        strb_o.addr_sel = 1'b1;
                        strb_o.acc_src  = 1'b1;
                        strb_o.acc_load = mem_ready_i;
                    end
                    OP_STA: begin
                        strb_o.mem_wr   = 1'b1;
                        strb_o.addr_sel = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                    OP_NOT, OP_SHL, OP_SHR: begin
                        strb_o.alu_op   = to_alu_op(opcode_i);
                        strb_o.acc_load = 1'b1;
                        strb_o.fr_load  = 1'b1;
                    end
                    OP_JMP:  strb_o.pc_load = 1'b1;
                    OP_JZ:   strb_o.pc_load = z_i;
                    OP_JC:   strb_o.pc_load = cy_i;
                    OP_JS:   strb_o.pc_load = s_i;
                    default: ;
                endcase
            end
            ST_HALT: strb_o.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle instruction sequencer for the 8-bit accumulator CPU.
// 3 cycles for one-byte ops, 4 for two-byte ops at zero wait; each wait cycle adds one.
// Memory requests are held until MEM_READY; the sequencer never withdraws a request.
module cpu_seq
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] MEM_DATA,
    input  logic       MEM_READY,
    input  logic       CY,
    input  logic       Z,
    input  logic       S,
    output logic       MEM_RD,
    output logic       MEM_WR,
    output logic       ADDR_SEL,
    output logic       PC_INC,
    output logic       PC_LOAD,
    output logic [3:0] ALU_OP,
    output logic       ACC_LOAD,
    output logic       ACC_SRC,
    output logic       FR_LOAD,
    output logic [7:0] OPERAND,
    output logic       HALTED
);

    state_t     state_q, state_d;
    // Only IR[7:4] carries meaning, so only the opcode nibble is kept.
    opcode_t    ir_q, ir_d;
    logic [7:0] operand_q, operand_d;
    strobe_t    strb;

    cpu_seq_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (ir_q),
        .mem_ready_i (MEM_READY),
        .cy_i        (CY),
        .z_i         (Z),
        .s_i         (S),
        .strb_o      (strb)
    );

    // Next-state and register-load logic; MEM_READY only matters in request states.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        operand_d = operand_q;
        case (state_q)
            ST_RESET_LD: state_d = ST_FETCH;
            ST_FETCH: begin
                if (MEM_READY) begin
                    ir_d    = opcode_t'(MEM_DATA[7:4]);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_two_byte(ir_q)) begin
                    state_d = ST_OPFETCH;
                end else if (ir_q == OP_HLT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_OPFETCH: begin
                if (MEM_READY) begin
                    operand_d = MEM_DATA;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Memory ops wait for completion; everything else is single-cycle.
                if (((ir_q != OP_LDA) && (ir_q != OP_STA)) || MEM_READY) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RESET_LD;
        endcase
    end

    // Sequencer state, IR and OPERAND registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_RESET_LD;
            ir_q      <= OP_NOP;
            operand_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            operand_q <= operand_d;
        end
    end

    assign MEM_RD   = strb.mem_rd;
    assign MEM_WR   = strb.mem_wr;
    assign ADDR_SEL = strb.addr_sel;
    assign PC_INC   = strb.pc_inc;
    assign PC_LOAD  = strb.pc_load;
    assign ALU_OP   = strb.alu_op;
    assign ACC_LOAD = strb.acc_load;
    assign ACC_SRC  = strb.acc_src;
    assign FR_LOAD  = strb.fr_load;
    assign HALTED   = strb.halted;
    assign OPERAND  = operand_q;

endmodule
